instruction_fetch: RTL and testbench

//   Fetch stage directly downstream of the program counter: samples the current PC, runs a
//   req/ack read to instruction memory, and holds the fetched word for decode under a

---
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: samples pc, runs a req/ack read to imem and holds the word for decode.
// Latency: req one cycle after fetch_en, ins_valid one cycle after ack; ins held while ins_ready is low.
module instruction_fetch #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [ADDR_W-1:0] next_pc,
  output logic              next_pc_valid,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  assign next_pc       = ins_pc + ADDR_W'(4);
  assign next_pc_valid = ins_valid & ins_ready & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      ins        <= '0;
      ins_pc     <= '0;
      ins_valid  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      wait_cnt   <= '0;
    end else if (flush) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      ins_valid  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      wait_cnt   <= '0;
    end else begin
      case (state)
        // IDLE and an accepted HOLD share the issue path so back-to-back fetches need no extra cycle.
        IDLE, HOLD: begin
          if (state == IDLE || ins_ready) begin
            ins_valid <= 1'b0;
            state     <= IDLE;
            if (fetch_en) begin
              if (pc[1:0] != 2'b00) begin
                state      <= FAULT;
                fault      <= 1'b1;
                fault_code <= 2'b01;
              end else begin
                imem_addr <= pc;
                imem_req  <= 1'b1;
                wait_cnt  <= '0;
                state     <= FETCH;
              end
            end
          end
        end
        FETCH: begin
          if (imem_ack) begin
            ins       <= imem_rdata;
            ins_pc    <= imem_addr;
            ins_valid <= 1'b1;
            imem_req  <= 1'b0;
            state     <= HOLD;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            imem_req   <= 1'b0;
            fault      <= 1'b1;
            fault_code <= 2'b10;
            state      <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          // FAULT is sticky until flush or reset.
          imem_req  <= 1'b0;
          ins_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic against a transaction-level model.
module tb_instruction_fetch;

  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_en, flush, imem_ack, ins_ready;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, ins, ins_pc, next_pc;
  logic        imem_req, ins_valid, next_pc_valid, fault;
  logic [1:0]  fault_code;

  int vectors = 0;
  int errors  = 0;

  // Reference: an outstanding read (with its age), a held word, and a sticky fault code.
  logic        m_busy, m_have, m_fault;
  logic [1:0]  m_code;
  logic [31:0] m_addr, m_ins, m_ins_pc;
  int          m_waited;

  instruction_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .next_pc(next_pc), .next_pc_valid(next_pc_valid), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_have = 0; m_fault = 0; m_code = 2'b00;
    m_addr = 0; m_ins = 0; m_ins_pc = 0; m_waited = 0;
  endtask

  task automatic model_issue();
    if (fetch_en) begin
      if (pc % 4 != 0) begin
        m_fault = 1; m_code = 2'b01;
      end else begin
        m_busy = 1; m_addr = pc; m_waited = 0;
      end
    end
  endtask

  // Applies the inputs currently on the pins for the coming clock edge.
  task automatic model_clock();
    if (flush) begin
      m_busy = 0; m_have = 0; m_fault = 0; m_code = 2'b00;
    end else if (m_fault) begin
    end else if (m_busy) begin
      if (imem_ack) begin
        m_busy = 0; m_have = 1; m_ins = imem_rdata; m_ins_pc = m_addr;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_busy = 0; m_fault = 1; m_code = 2'b10;
        end
      end
    end else if (m_have) begin
      if (ins_ready) begin
        m_have = 0;
        model_issue();
      end
    end else begin
      model_issue();
    end
  endtask

  task automatic check_all();
    check("imem_req",      imem_req,      m_busy);
    check("imem_addr",     imem_addr,     m_addr);
    check("ins_valid",     ins_valid,     m_have);
    check("ins",           ins,           m_ins);
    check("ins_pc",        ins_pc,        m_ins_pc);
    check("next_pc",       next_pc,       m_ins_pc + 32'd4);
    check("next_pc_valid", next_pc_valid, m_have & ins_ready & ~flush);
    check("fault",         fault,         m_fault);
    check("fault_code",    fault_code,    m_code);
  endtask

  task automatic step(input logic fe, input logic fl, input logic ack,
                      input logic [31:0] rd, input logic rdy, input logic [31:0] p);
    @(negedge clk);
    fetch_en = fe; flush = fl; imem_ack = ack; imem_rdata = rd; ins_ready = rdy; pc = p;
    #1;
    check_all();
    model_clock();
  endtask

  initial begin
    reset = 1; pc = 0; fetch_en = 0; flush = 0; imem_ack = 0; ins_ready = 0; imem_rdata = 0;
    model_reset();
    #12;
    check_all();
    check("rst_next_pc", next_pc, 64'h4);
    @(negedge clk);
    reset = 0;

    // 1: basic fetch, ack two cycles after req
    step(1, 0, 0, 0, 0, 32'h100);
    step(0, 0, 0, 0, 0, 32'h100);
    check("t1_req", imem_req, 1);
    step(0, 0, 0, 0, 0, 32'h100);
    step(0, 0, 1, 32'hDEADBEEF, 0, 32'h100);
    step(0, 0, 0, 0, 1, 32'h100);
    check("t1_ins", ins, 32'hDEADBEEF);
    check("t1_ins_pc", ins_pc, 32'h100);
    check("t1_next_pc", next_pc, 32'h104);
    check("t1_npv", next_pc_valid, 1);
    step(0, 0, 0, 0, 1, 32'h104);
    check("t1_npv_one", next_pc_valid, 0);

    // 2: decode stalls for 5 cycles while fetch_en stays high
    step(1, 0, 0, 0, 0, 32'h200);
    step(0, 0, 1, 32'h12345678, 0, 32'h200);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 32'h204);
    check("t2_hold_ins", ins, 32'h12345678);
    step(0, 0, 0, 0, 1, 32'h204);

    // 3: misaligned pc faults without a request
    step(1, 0, 0, 0, 0, 32'h102);
    step(1, 0, 0, 0, 0, 32'h104);
    check("t3_code", fault_code, 2'b01);
    check("t3_noreq", imem_req, 0);
    step(0, 1, 0, 0, 0, 32'h104);
    step(0, 0, 0, 0, 0, 32'h104);
    check("t3_cleared", fault, 0);

    // 4: ack timeout, then a late ack that must be ignored
    step(1, 0, 0, 0, 0, 32'h300);
    for (int i = 0; i < TMO + 1; i++) step(0, 0, 0, 0, 0, 32'h300);
    step(0, 0, 1, 32'hCAFEF00D, 0, 32'h300);
    step(0, 0, 0, 0, 0, 32'h300);
    check("t4_code", fault_code, 2'b10);
    check("t4_noins", ins_valid, 0);
    step(0, 1, 0, 0, 0, 32'h300);

    // 5: flush against ack, then flush against ready
    step(1, 0, 0, 0, 0, 32'h400);
    step(0, 1, 1, 32'h11111111, 0, 32'h400);
    step(0, 0, 0, 0, 0, 32'h400);
    check("t5_ack_killed", ins_valid, 0);
    step(1, 0, 0, 0, 0, 32'h404);
    step(0, 0, 1, 32'h22222222, 0, 32'h404);
    step(0, 1, 0, 0, 1, 32'h404);
    step(0, 0, 0, 0, 1, 32'h404);

    // 6: async reset between edges during a fetch
    step(1, 0, 0, 0, 0, 32'h500);
    step(0, 0, 0, 0, 0, 32'h500);
    @(posedge clk);
    #2 reset = 1;
    #1;
    model_reset();
    check("t6_req_drop", imem_req, 0);
    check_all();
    @(negedge clk);
    fetch_en = 0; flush = 0; imem_ack = 0; ins_ready = 0;
    reset = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
      step($urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 4 : 1), $urandom,
           $urandom_range(0, 1) == 1, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
